control_corriente: RTL and testbench

Front-end controller for the current-selection datapath (`Seleccion_Corriente`). It takes raw, bouncy front-panel buttons and synchronises and debounces them. It turns each press into single-cycle step commands on `botones`, with hold-to-repeat, and refuses steps that would push the selected current `I` past configured limits. It drives the datapath's `botones` and `ENi` inputs and reads back its `I` output.

---
 rtl/control_corriente.sv | 175 +++++++++++++++++
 tb/tb_control_corriente.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_corriente.sv
// Front-panel controller for the current-selection datapath: synchronises and
// debounces the up/down buttons and turns presses into single-cycle step commands
// with hold-to-repeat. Steps that would move I past the configured limits are
// suppressed.
`timescale 1ns/1ps
module control_corriente #(
    parameter int unsigned DEB_CYC = 4,    // must be >= 2
    parameter int unsigned REP_DLY = 20,
    parameter int unsigned REP_PER = 5,
    parameter int unsigned I_MIN   = 0,
    parameter int unsigned I_MAX   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn_raw,
    input  logic       en_sys,
    input  logic [9:0] I,
    output logic [1:0] botones,
    output logic       ENi,
    output logic       at_limit,
    output logic       busy
);

    localparam int unsigned DW   = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
    localparam int unsigned RMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [DW-1:0] DEB_FIRE = DW'(DEB_CYC - 2);
    localparam logic [RW-1:0] REP_DLY_LD = RW'(REP_DLY - 1);
    localparam logic [RW-1:0] REP_PER_LD = RW'(REP_PER - 1);
    localparam logic [9:0]    L_I_MIN = 10'(I_MIN);
    localparam logic [9:0]    L_I_MAX = 10'(I_MAX);

    typedef enum logic [1:0] {StIdle, StPress, StHold, StRepeat} state_t;

    logic [1:0]    r_sync1, r_btn_s, r_cand, r_btn_d;
    logic [DW-1:0] r_deb_cnt;
    logic          w_same;

    state_t        r_state, w_state_nxt;
    logic [RW-1:0] r_rep_cnt, w_rep_nxt;
    logic [1:0]    r_dir, w_dir_nxt;
    logic [1:0]    r_botones, w_bot_nxt;
    logic          r_at_limit, w_lim_nxt;
    logic          r_eni;
    logic          w_valid, w_blocked, w_fire;

    // Two-flop synchroniser on each raw button bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 2'b00;
            r_btn_s <= 2'b00;
        end else begin
            r_sync1 <= btn_raw;
            r_btn_s <= r_sync1;
        end
    end

    assign w_same = (r_btn_s == r_cand);

    // Debounce: accept the candidate once it has been sampled DEB_CYC times in a row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cand    <= 2'b00;
            r_deb_cnt <= DEB_LAST;
            r_btn_d   <= 2'b00;
        end else if (!w_same) begin
            r_cand    <= r_btn_s;
            r_deb_cnt <= '0;
        end else begin
            if (r_deb_cnt != DEB_LAST) begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
            if (r_deb_cnt == DEB_FIRE) begin
                r_btn_d <= r_cand;
            end
        end
    end

    assign w_valid   = (r_btn_d == 2'b10) || (r_btn_d == 2'b01);
    assign w_blocked = ((r_dir == 2'b10) && (I >= L_I_MAX)) ||
                       ((r_dir == 2'b01) && (I <= L_I_MIN));

    // FSM state, repeat counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_rep_cnt  <= '0;
            r_dir      <= 2'b00;
            r_botones  <= 2'b00;
            r_at_limit <= 1'b0;
            r_eni      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rep_cnt  <= w_rep_nxt;
            r_dir      <= w_dir_nxt;
            r_botones  <= w_bot_nxt;
            r_at_limit <= w_lim_nxt;
            r_eni      <= en_sys;
        end
    end

    // Next-state logic: press, initial delay, periodic repeat, abort on change or disable
    always_comb begin
        w_state_nxt = r_state;
        w_rep_nxt   = r_rep_cnt;
        w_dir_nxt   = r_dir;
        w_bot_nxt   = 2'b00;
        w_lim_nxt   = r_at_limit;
        w_fire      = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_lim_nxt = 1'b0;
                if (w_valid) begin
                    w_dir_nxt   = r_btn_d;
                    w_state_nxt = StPress;
                end
            end
            StPress: begin
                w_fire      = 1'b1;
                w_rep_nxt   = REP_DLY_LD;
                w_state_nxt = StHold;
            end
            StHold: begin
                if (r_rep_cnt == '0) begin
                    w_fire      = 1'b1;
                    w_rep_nxt   = REP_PER_LD;
                    w_state_nxt = StRepeat;
                end else begin
                    w_rep_nxt = r_rep_cnt - 1'b1;
                end
            end
            StRepeat: begin
                if (r_rep_cnt == '0) begin
                    w_fire    = 1'b1;
                    w_rep_nxt = REP_PER_LD;
                end else begin
                    w_rep_nxt = r_rep_cnt - 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        // Suppressed steps keep the repeat schedule running but raise at_limit
        if (w_fire) begin
            if (w_blocked) begin
                w_lim_nxt = 1'b1;
            end else begin
                w_bot_nxt = r_dir;
                w_lim_nxt = 1'b0;
            end
        end

        // Any change of the debounced buttons ends the press with no step this cycle
        if ((r_state != StIdle) && (r_btn_d != r_dir)) begin
            w_state_nxt = StIdle;
            w_bot_nxt   = 2'b00;
            w_lim_nxt   = 1'b0;
        end

        if (!en_sys) begin
            w_state_nxt = StIdle;
            w_bot_nxt   = 2'b00;
            w_lim_nxt   = 1'b0;
        end
    end

    assign botones  = r_botones;
    assign ENi      = r_eni;
    assign at_limit = r_at_limit;
    assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_control_corriente.sv
// Self-checking bench for control_corriente: expected step pulses are queued with
// their due cycle and checked by a per-cycle monitor; flags checked inline per task.
`timescale 1ns/1ps
module tb_control_corriente;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_raw = 2'b00;
    logic       en_sys = 1'b0;
    logic [9:0] I = 10'd500;
    logic [1:0] botones;
    logic       ENi;
    logic       at_limit;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [1:0] val;
    } exp_t;

    exp_t sb[$];

    control_corriente dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .en_sys   (en_sys),
        .I        (I),
        .botones  (botones),
        .ENi      (ENi),
        .at_limit (at_limit),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor: every cycle either a queued pulse is due or botones must be idle
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc = cyc + 1;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            if (botones !== e.val) begin
                errors++;
                $display("FAIL pulse at cycle %0d: got %b, expected %b", cyc, botones, e.val);
            end
        end else if (botones !== 2'b00) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse at cycle %0d: got %b, expected 00", cyc, botones);
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        btn_raw = 2'b10;
        en_sys  = 1'b1;
        I       = 10'd500;
        #1 rst = 1'b0;
        #100;
        checks++;
        if ({botones, ENi, at_limit, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 00000", {botones, ENi, at_limit, busy});
        end
        @(negedge clk);
        rst = 1'b1;
        n = cyc;
        checks++;
        if (ENi !== 1'b0) begin
            errors++;
            $display("FAIL eni_before_edge: got %b, expected 0", ENi);
        end
        sb.push_back('{n + 8, 2'b10});
        @(posedge clk);
        #2;
        checks++;
        if (ENi !== 1'b1) begin
            errors++;
            $display("FAIL eni_after_edge: got %b, expected 1", ENi);
        end
        wait_until(n + 8);
        btn_raw = 2'b00;
        wait_until(n + 30);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_end: got %b, expected 0", busy);
        end
    endtask

    task automatic test_single_press();
        int n;
        I = 10'd500;
        @(negedge clk);
        btn_raw = 2'b10;
        n = cyc;
        sb.push_back('{n + 8, 2'b10});
        wait_until(n + 10);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_mid: got %b, expected 1", busy);
        end
        btn_raw = 2'b00;
        wait_until(n + 35);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_end: got %b, expected 0", busy);
        end
    endtask

    task automatic test_hold_down();
        int n;
        int t0;
        I = 10'd500;
        @(negedge clk);
        btn_raw = 2'b01;
        n  = cyc;
        t0 = n + 8;
        sb.push_back('{t0, 2'b01});
        for (int j = 0; j < 7; j++) sb.push_back('{t0 + 20 + 5 * j, 2'b01});
        wait_until(t0 + 45);
        btn_raw = 2'b00;
        wait_until(t0 + 62);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_busy_end: got %b, expected 0", busy);
        end
    endtask

    task automatic test_bounce();
        int n8;
        n8 = 0;
        I = 10'd500;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            btn_raw = (((i / 2) % 2) == 0) ? 2'b10 : 2'b00;
            if (i == 8) n8 = cyc;
        end
        sb.push_back('{n8 + 8, 2'b10});
        wait_until(n8 + 8);
        btn_raw = 2'b00;
        wait_until(n8 + 30);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bounce_busy_end: got %b, expected 0", busy);
        end
    endtask

    task automatic test_limits();
        int n;
        // up at the top limit
        I = 10'd1000;
        @(negedge clk);
        btn_raw = 2'b10;
        n = cyc;
        wait_until(n + 8);
        checks++;
        if (at_limit !== 1'b1) begin
            errors++;
            $display("FAIL limit_up_flag: got %b, expected 1", at_limit);
        end
        wait_until(n + 10);
        btn_raw = 2'b00;
        wait_until(n + 22);
        checks++;
        if (at_limit !== 1'b0) begin
            errors++;
            $display("FAIL limit_up_clear: got %b, expected 0", at_limit);
        end
        // down at the bottom limit
        I = 10'd0;
        @(negedge clk);
        btn_raw = 2'b01;
        n = cyc;
        wait_until(n + 8);
        checks++;
        if (at_limit !== 1'b1) begin
            errors++;
            $display("FAIL limit_down_flag: got %b, expected 1", at_limit);
        end
        wait_until(n + 10);
        btn_raw = 2'b00;
        wait_until(n + 22);
        // down from the top limit is allowed
        I = 10'd1000;
        @(negedge clk);
        btn_raw = 2'b01;
        n = cyc;
        sb.push_back('{n + 8, 2'b01});
        wait_until(n + 8);
        checks++;
        if (at_limit !== 1'b0) begin
            errors++;
            $display("FAIL limit_down_ok_flag: got %b, expected 0", at_limit);
        end
        wait_until(n + 10);
        btn_raw = 2'b00;
        wait_until(n + 25);
        I = 10'd500;
    endtask

    task automatic test_limit_in_repeat();
        int n;
        int t0;
        I = 10'd500;
        @(negedge clk);
        btn_raw = 2'b10;
        n  = cyc;
        t0 = n + 8;
        sb.push_back('{t0, 2'b10});
        sb.push_back('{t0 + 20, 2'b10});
        wait_until(t0 + 22);
        I = 10'd1000;
        wait_until(t0 + 25);
        checks++;
        if (at_limit !== 1'b1) begin
            errors++;
            $display("FAIL repeat_limit_flag: got %b, expected 1", at_limit);
        end
        wait_until(t0 + 26);
        btn_raw = 2'b00;
        wait_until(t0 + 40);
        checks++;
        if ({at_limit, busy} !== 2'b00) begin
            errors++;
            $display("FAIL repeat_limit_end: got %b, expected 00", {at_limit, busy});
        end
        I = 10'd500;
    endtask

    task automatic test_both_buttons();
        int n;
        @(negedge clk);
        btn_raw = 2'b11;
        n = cyc;
        wait_until(n + 12);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL both_busy: got %b, expected 0", busy);
        end
        btn_raw = 2'b00;
        wait_until(n + 22);
    endtask

    task automatic test_enable_drop();
        int n;
        int t0;
        I = 10'd500;
        @(negedge clk);
        btn_raw = 2'b10;
        n  = cyc;
        t0 = n + 8;
        sb.push_back('{t0, 2'b10});
        sb.push_back('{t0 + 20, 2'b10});
        sb.push_back('{t0 + 25, 2'b10});
        // drop enable so it is seen on the very edge the next repeat is due
        wait_until(t0 + 29);
        en_sys = 1'b0;
        wait_until(t0 + 30);
        checks++;
        if ({busy, ENi} !== 2'b00) begin
            errors++;
            $display("FAIL enable_drop: got busy,ENi=%b, expected 00", {busy, ENi});
        end
        wait_until(t0 + 42);
        btn_raw = 2'b00;
        wait_until(t0 + 55);
        en_sys = 1'b1;
        wait_until(t0 + 65);
        checks++;
        if ({busy, ENi} !== 2'b01) begin
            errors++;
            $display("FAIL enable_restore: got busy,ENi=%b, expected 01", {busy, ENi});
        end
    endtask

    task automatic test_reset_mid_hold();
        int n;
        int t0;
        I = 10'd500;
        @(negedge clk);
        btn_raw = 2'b10;
        n  = cyc;
        t0 = n + 8;
        sb.push_back('{t0, 2'b10});
        wait_until(t0 - 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({botones, ENi, at_limit, busy} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: got %b, expected 00000", {botones, ENi, at_limit, busy});
        end
        @(negedge clk);
        btn_raw = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        n = cyc;
        wait_until(n + 30);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_busy: got %b, expected 0", busy);
        end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_press();
        test_hold_down();
        test_bounce();
        test_limits();
        test_limit_in_repeat();
        test_both_buttons();
        test_enable_drop();
        test_reset_mid_hold();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
